// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS datapath/memory.
// master = control FSM (drives control lines), slave = datapath + shared memory.
// Carries the opcode/run inputs, the mem_ready handshake and every control output.
interface multicycle_control_fsm_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, bus_error, state
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, bus_error, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) driving all datapath control lines.
// Latency: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles with mem_ready high.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_ready; WAIT_MAX timeout sets sticky bus_error.
// Optional: define MULTICYCLE_CTRL_EXC_EN to trap illegal opcodes into EXC (else NOP).
module multicycle_control_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int WCNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master ctl
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12,
    EXC      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_MAX);

  // State-only (Moore) control lines; registered alongside the state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              bus_error_q, bus_error_d;
  ctrl_t             ctrl_q;
  logic              mem_state;
  logic              timeout;
  logic              retire;
  logic              fetch_done;

  function automatic ctrl_t moore_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:   c.alu_src_b = 2'b11;
      MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      EXEC:     begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                      c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDI_WB:  c.reg_write = 1'b1;
      EXC:      begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state, wait-counter and retire decode.
  always_comb begin
    mem_state   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    timeout     = mem_state && !ctl.mem_ready && (wcnt_q == WCNT_MAX);
    retire      = 1'b0;
    state_d     = state_q;
    bus_error_d = bus_error_q;
    // Counter runs only while stalled in a memory state; any exit clears it.
    wcnt_d      = '0;
    if (mem_state && !ctl.mem_ready && !timeout)
      wcnt_d = wcnt_q + 1'b1;

    case (state_q)
      IDLE:     if (ctl.run && !bus_error_q) state_d = FETCH;
      FETCH:    if (ctl.mem_ready) state_d = DECODE;
      DECODE: begin
        case (ctl.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
`ifdef MULTICYCLE_CTRL_EXC_EN
          default:      state_d = EXC;
`else
          default:      retire  = 1'b1;
`endif
        endcase
      end
      MEM_ADDR: state_d = (ctl.opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (ctl.mem_ready) state_d = MEM_WB;
      MEM_WB:   retire  = 1'b1;
      MEM_WR:   retire  = ctl.mem_ready;
      EXEC:     state_d = R_WB;
      R_WB:     retire  = 1'b1;
      BRANCH:   retire  = 1'b1;
      JUMP:     retire  = 1'b1;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  retire  = 1'b1;
      EXC:      state_d = ctl.run ? FETCH : IDLE;
      default:  state_d = IDLE;
    endcase

    // run is only consulted once the instruction has completed.
    if (retire)
      state_d = ctl.run ? FETCH : IDLE;
    if (timeout) begin
      state_d     = IDLE;
      bus_error_d = 1'b1;
    end
  end

  // State, counter, sticky error and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      bus_error_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bus_error_q <= bus_error_d;
      ctrl_q      <= moore_ctrl(state_d);
    end
  end

  // Mealy outputs: the fetch handshake completion and instruction retirement.
  assign fetch_done        = (state_q == FETCH) && ctl.mem_ready;
  assign ctl.ir_write      = fetch_done;
  assign ctl.pc_write      = ctrl_q.pc_write | fetch_done;
  assign ctl.instr_done    = retire;

  assign ctl.pc_write_cond = ctrl_q.pc_write_cond;
  assign ctl.i_or_d        = ctrl_q.i_or_d;
  assign ctl.mem_read      = ctrl_q.mem_read;
  assign ctl.mem_write     = ctrl_q.mem_write;
  assign ctl.reg_dst       = ctrl_q.reg_dst;
  assign ctl.mem_to_reg    = ctrl_q.mem_to_reg;
  assign ctl.reg_write     = ctrl_q.reg_write;
  assign ctl.alu_src_a     = ctrl_q.alu_src_a;
  assign ctl.alu_src_b     = ctrl_q.alu_src_b;
  assign ctl.alu_op        = ctrl_q.alu_op;
  assign ctl.pc_source     = ctrl_q.pc_source;
  assign ctl.bus_error     = bus_error_q;
  assign ctl.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction sequences, memory stalls,
// wait-timeout boundary, illegal opcode, async reset mid-write.
// Inputs change 2 time units after a rising edge; outputs are checked before the next edge.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   rw_cnt = 0;
  int   irw_cnt = 0;
  int   rw0;
  int   irw0;

  multicycle_control_fsm_if ctl_if();

  multicycle_control_fsm #(.WAIT_MAX(15), .WCNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl_if)
  );

  always #5 clk = ~clk;

  // Count write-enable pulses mid-cycle.
  always @(negedge clk) begin
    if (ctl_if.reg_write === 1'b1) rw_cnt++;
    if (ctl_if.ir_write === 1'b1) irw_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [16:0] ctl_vec();
    return {ctl_if.pc_write, ctl_if.pc_write_cond, ctl_if.i_or_d, ctl_if.mem_read,
            ctl_if.mem_write, ctl_if.ir_write, ctl_if.reg_dst, ctl_if.mem_to_reg,
            ctl_if.reg_write, ctl_if.alu_src_a, ctl_if.alu_src_b, ctl_if.alu_op,
            ctl_if.pc_source, ctl_if.instr_done};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    ctl_if.run = 1'b0;
    ctl_if.opcode = 6'b000000;
    ctl_if.mem_ready = 1'b0;
    #3;
    chk("rst_state", 32'(ctl_if.state), 32'd0);
    chk("rst_ctl", 32'(ctl_vec()), 32'd0);
    chk("rst_berr", 32'(ctl_if.bus_error), 32'd0);

    // R-type, mem_ready high: 0,1,2,7,8,1
    @(negedge clk);
    reset = 1'b1;
    ctl_if.run = 1'b1;
    ctl_if.mem_ready = 1'b1;
    tick();
    chk("r_fetch_state", 32'(ctl_if.state), 32'd1);
    chk("r_fetch_memrd", 32'(ctl_if.mem_read), 32'd1);
    chk("r_fetch_srcb", 32'(ctl_if.alu_src_b), 32'd1);
    chk("r_fetch_irw", 32'(ctl_if.ir_write), 32'd1);
    chk("r_fetch_pcw", 32'(ctl_if.pc_write), 32'd1);
    tick();
    chk("r_dec_state", 32'(ctl_if.state), 32'd2);
    chk("r_dec_srcb", 32'(ctl_if.alu_src_b), 32'd3);
    chk("r_dec_irw", 32'(ctl_if.ir_write), 32'd0);
    tick();
    chk("r_exec_state", 32'(ctl_if.state), 32'd7);
    chk("r_exec_aluop", 32'(ctl_if.alu_op), 32'd2);
    chk("r_exec_regw", 32'(ctl_if.reg_write), 32'd0);
    tick();
    chk("r_wb_state", 32'(ctl_if.state), 32'd8);
    chk("r_wb_regw", 32'(ctl_if.reg_write), 32'd1);
    chk("r_wb_regdst", 32'(ctl_if.reg_dst), 32'd1);
    chk("r_wb_done", 32'(ctl_if.instr_done), 32'd1);
    tick();
    chk("r_next_state", 32'(ctl_if.state), 32'd1);
    chk("r_next_done", 32'(ctl_if.instr_done), 32'd0);

    // lw with 3 stall cycles in MEM_RD
    ctl_if.opcode = 6'b100011;
    rw0 = rw_cnt;
    tick();
    chk("lw_dec_state", 32'(ctl_if.state), 32'd2);
    tick();
    chk("lw_addr_state", 32'(ctl_if.state), 32'd3);
    chk("lw_addr_srcb", 32'(ctl_if.alu_src_b), 32'd2);
    chk("lw_addr_srca", 32'(ctl_if.alu_src_a), 32'd1);
    ctl_if.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) begin
        ctl_if.mem_ready = 1'b1;
        #1;
      end
      chk("lw_rd_state", 32'(ctl_if.state), 32'd4);
      chk("lw_rd_iord", 32'({ctl_if.mem_read, ctl_if.i_or_d}), 32'd3);
    end
    tick();
    chk("lw_wb_state", 32'(ctl_if.state), 32'd5);
    chk("lw_wb_m2r", 32'({ctl_if.reg_write, ctl_if.mem_to_reg}), 32'd3);
    chk("lw_wb_done", 32'(ctl_if.instr_done), 32'd1);
    tick();
    chk("lw_next_state", 32'(ctl_if.state), 32'd1);
    chk("lw_regw_once", 32'(rw_cnt - rw0), 32'd1);
    chk("lw_berr", 32'(ctl_if.bus_error), 32'd0);

    // sw: mem_ready arrives exactly when the count hits WAIT_MAX
    ctl_if.opcode = 6'b101011;
    tick();
    tick();
    chk("sw_addr_state", 32'(ctl_if.state), 32'd3);
    ctl_if.mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) begin
        ctl_if.mem_ready = 1'b1;
        #1;
        chk("sw_edge_done", 32'(ctl_if.instr_done), 32'd1);
      end
      chk("sw_wr_state", 32'(ctl_if.state), 32'd6);
      chk("sw_wr_memw", 32'(ctl_if.mem_write), 32'd1);
    end
    tick();
    chk("sw_next_state", 32'(ctl_if.state), 32'd1);
    chk("sw_berr", 32'(ctl_if.bus_error), 32'd0);

    // beq then j, run dropped in JUMP
    ctl_if.opcode = 6'b000100;
    tick();
    tick();
    chk("beq_state", 32'(ctl_if.state), 32'd9);
    chk("beq_pcwc", 32'(ctl_if.pc_write_cond), 32'd1);
    chk("beq_pcsrc", 32'(ctl_if.pc_source), 32'd1);
    chk("beq_aluop", 32'(ctl_if.alu_op), 32'd1);
    chk("beq_done", 32'(ctl_if.instr_done), 32'd1);
    tick();
    chk("beq_next_state", 32'(ctl_if.state), 32'd1);
    ctl_if.opcode = 6'b000010;
    tick();
    tick();
    chk("j_state", 32'(ctl_if.state), 32'd10);
    chk("j_pcw", 32'(ctl_if.pc_write), 32'd1);
    chk("j_pcsrc", 32'(ctl_if.pc_source), 32'd2);
    chk("j_done", 32'(ctl_if.instr_done), 32'd1);
    ctl_if.run = 1'b0;
    tick();
    chk("j_idle_state", 32'(ctl_if.state), 32'd0);
    chk("j_idle_ctl", 32'(ctl_vec()), 32'd0);
    tick();
    chk("idle_hold", 32'(ctl_if.state), 32'd0);

    // illegal opcode
    ctl_if.run = 1'b1;
    ctl_if.opcode = 6'b111111;
    tick();
    chk("ill_fetch", 32'(ctl_if.state), 32'd1);
    tick();
    chk("ill_dec", 32'(ctl_if.state), 32'd2);
`ifdef MULTICYCLE_CTRL_EXC_EN
    chk("ill_dec_done", 32'(ctl_if.instr_done), 32'd0);
    tick();
    chk("exc_state", 32'(ctl_if.state), 32'd13);
    chk("exc_pcw", 32'(ctl_if.pc_write), 32'd1);
    chk("exc_pcsrc", 32'(ctl_if.pc_source), 32'd3);
    chk("exc_done", 32'(ctl_if.instr_done), 32'd0);
`else
    chk("ill_dec_done", 32'(ctl_if.instr_done), 32'd1);
`endif
    tick();
    chk("ill_next_state", 32'(ctl_if.state), 32'd1);

    // addi
    ctl_if.opcode = 6'b001000;
    tick();
    tick();
    chk("addi_ex_state", 32'(ctl_if.state), 32'd11);
    chk("addi_ex_srcb", 32'(ctl_if.alu_src_b), 32'd2);
    tick();
    chk("addi_wb_state", 32'(ctl_if.state), 32'd12);
    chk("addi_wb_ctl", 32'({ctl_if.reg_write, ctl_if.reg_dst, ctl_if.mem_to_reg}), 32'd4);
    chk("addi_wb_done", 32'(ctl_if.instr_done), 32'd1);
    tick();
    chk("addi_next_state", 32'(ctl_if.state), 32'd1);

    // async reset while MEM_WR is stalled
    ctl_if.opcode = 6'b101011;
    tick();
    tick();
    ctl_if.mem_ready = 1'b0;
    tick();
    chk("arst_pre_memw", 32'(ctl_if.mem_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_memw", 32'(ctl_if.mem_write), 32'd0);
    chk("arst_state", 32'(ctl_if.state), 32'd0);
    chk("arst_ctl", 32'(ctl_vec()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // FETCH timeout with mem_ready stuck low
    irw0 = irw_cnt;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("to_fetch_state", 32'(ctl_if.state), 32'd1);
      chk("to_berr_low", 32'(ctl_if.bus_error), 32'd0);
      tick();
    end
    chk("to_idle_state", 32'(ctl_if.state), 32'd0);
    chk("to_berr", 32'(ctl_if.bus_error), 32'd1);
    chk("to_irw_none", 32'(irw_cnt - irw0), 32'd0);
    tick();
    tick();
    chk("to_run_ignored", 32'(ctl_if.state), 32'd0);
    chk("to_berr_sticky", 32'(ctl_if.bus_error), 32'd1);
    reset = 1'b0;
    #1;
    chk("to_berr_rst", 32'(ctl_if.bus_error), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore/Mealy control FSM that sequences the team's MIPS datapath as a multi-cycle machine: IF -> ID -> EX -> MEM -> WB.
- Drives every datapath control line from the opcode in instruction[31:26].
- Stalls on a shared instruction/data memory through a ready handshake, with a wait-timeout counter.
- Replaces the single-cycle Control_Unit; ALU_control still decodes funct from alu_op.

Parameters:
- WAIT_MAX, 15: maximum cycles a memory state waits for mem_ready before abandoning the access.
- WCNT_W, 4: width of the wait counter; must satisfy 2^WCNT_W > WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- run  in  1  1 = execute instructions; 0 = park in IDLE after the current instruction
- opcode  in  6  instruction[31:26], taken from the instruction register
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
- instr_done  out  1  one-cycle pulse when an instruction retires
- bus_error  out  1  sticky; set on mem_ready timeout
- state  out  4  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, EXC=13.
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, bus_error=0.
  - All control outputs and instr_done are 0 and stay 0 while in IDLE.
- IDLE: run=1 -> FETCH on the next edge; otherwise hold.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are Mealy outputs: asserted only in the cycle mem_ready=1. That cycle -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 (R-type) -> EXEC
  - 100011 (lw), 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EX
  - any other opcode -> see Optional Feature
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; mem_ready=1 -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; retire.
- MEM_WR: mem_write=1, i_or_d=1; retire in the cycle mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire.
- JUMP: pc_write=1, pc_source=10; retire.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; retire.
- Retire:
  - instr_done=1 during the final state's active cycle.
  - Next state = FETCH if run=1, else IDLE. run is sampled only at retire; dropping run mid-instruction never aborts it.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to these states; increments each cycle mem_ready=0.
  - When it reaches WAIT_MAX with mem_ready still 0: set bus_error, drop the request, go to IDLE, no instr_done, no ir_write/pc_write/reg_write.
  - mem_ready=1 in the same cycle the count reaches WAIT_MAX counts as success.
  - mem_ready is ignored in every non-memory state.
- Latencies with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles from FETCH entry.
- bus_error clears only on reset. While bus_error=1, run is ignored and the FSM stays in IDLE.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0; no partial write-back.

Optional Feature:
- Macro: MULTICYCLE_CTRL_EXC_EN
- Defined: an illegal opcode in DECODE -> EXC. EXC asserts pc_write=1 and pc_source=11 for one cycle, does not pulse instr_done, then goes to FETCH if run=1, else IDLE.
- Not defined: an illegal opcode is a NOP. DECODE retires directly, pulsing instr_done, and EXC is unreachable.

Test Plan:
- Reset release, run=1, mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1. reg_write=1 and reg_dst=1 only in R_WB; instr_done at cycle 4.
- lw (100011) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; reg_write=1 and mem_to_reg=1 exactly once; bus_error=0.
- FETCH with mem_ready held 0, WAIT_MAX=15 -> bus_error=1 after 15 cycles, state=IDLE, ir_write never asserted, run=1 ignored afterwards.
- beq (000100) then j (000010), run dropped during the j JUMP state -> pc_write_cond=1 in BRANCH; pc_write=1 with pc_source=10 in JUMP; FSM ends in IDLE.
- Opcode 111111 -> with MULTICYCLE_CTRL_EXC_EN defined: pc_source=11 and pc_write=1 for one cycle, no instr_done. Without the macro: instr_done pulse in DECODE.
- reset driven low during MEM_WR with mem_write=1 -> asynchronous return to IDLE, mem_write=0 before the next clock edge.
